// File: rtl/io_timer_bank_if.sv
// J1 I/O bus bundle for the timer bank: strobes, address, data and select.
interface io_timer_bank_if;
   logic        io_rd;
   logic        io_wr;
   logic [15:0] io_addr;
   logic [15:0] io_wdata;
   logic [15:0] io_rdata;
   logic        io_sel;

   modport master (
      output io_rd, io_wr, io_addr, io_wdata,
      input  io_rdata, io_sel
   );

   modport slave (
      input  io_rd, io_wr, io_addr, io_wdata,
      output io_rdata, io_sel
   );
endinterface

// File: rtl/io_timer_bank.sv
// Timing peripheral: prescaler, 32-bit tick clock with tear-free hi/lo read,
// and N_CH countdown channels with one-shot/auto-reload and sticky flags.
module io_timer_bank #(
   parameter logic [15:0] BASE_ADDR = 16'h6400,
   parameter int          CLK_DIV   = 68,
   parameter int          N_CH      = 4,
   parameter int          CNT_W     = 16
) (
   input  logic            sys_clk_i,
   input  logic            sys_rst_n_i,
   io_timer_bank_if.slave  io,
   output logic            tick_o,
   output logic [N_CH-1:0] expired_o
);
   localparam int PW = $clog2(CLK_DIV);
   localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);

   logic [PW-1:0]    pre_q;
   logic             tick_q;
   logic [31:0]      clk_q;
   logic [15:0]      shadow_q;
   logic [CNT_W-1:0] count_q  [N_CH];
   logic [CNT_W-1:0] reload_q [N_CH];
   logic [1:0]       ctrl_q   [N_CH];
   logic [N_CH-1:0]  flag_q;

   logic [5:0]      off;
   logic [3:0]      ch_idx;
   logic            ch_hit;
   logic            sel_lo;
   logic            sel_hi;
   logic            sel_fl;
   logic            wr_clr;
   logic            wr_flags;
   logic            rd_lo;
   logic [N_CH-1:0] wr_cnt;
   logic [N_CH-1:0] wr_ctl;
   logic [N_CH-1:0] expire;
   logic [N_CH-1:0] w1c;

   // The window is 64-byte aligned, so the low address bits are the offset.
   assign off       = io.io_addr[5:0];
   assign io.io_sel = (io.io_addr[15:6] == BASE_ADDR[15:6]);
   assign ch_idx    = off[5:2] - 4'd4;
   assign ch_hit    = io.io_sel && (off[5:4] != 2'b00);
   assign sel_lo    = io.io_sel && (off[5:1] == 5'h00);
   assign sel_hi    = io.io_sel && (off[5:1] == 5'h01);
   assign sel_fl    = io.io_sel && (off[5:1] == 5'h03);
   assign wr_clr    = io.io_sel && io.io_wr &&
                      (off[5:1] == 5'h02) && io.io_wdata[0];
   assign wr_flags  = sel_fl && io.io_wr;
   assign rd_lo     = sel_lo && io.io_rd;
   assign w1c       = wr_flags ? io.io_wdata[N_CH-1:0] : '0;

   // A clock clear suppresses the tick in the very cycle it is written.
   assign tick_o    = tick_q && !wr_clr;
   assign expired_o = flag_q;

   always_comb begin
      wr_cnt = '0;
      wr_ctl = '0;
      expire = '0;
      for (int k = 0; k < N_CH; k++) begin
         wr_cnt[k] = ch_hit && io.io_wr &&
                     (ch_idx == 4'(k)) && !off[1];
         wr_ctl[k] = ch_hit && io.io_wr &&
                     (ch_idx == 4'(k)) && off[1];
         expire[k] = tick_o && ctrl_q[k][0] &&
                     (count_q[k] == CNT_W'(1)) && !wr_cnt[k];
      end
   end

   always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
      if (!sys_rst_n_i) begin
         pre_q  <= '0;
         tick_q <= 1'b0;
         clk_q  <= '0;
      end else if (wr_clr) begin
         pre_q  <= '0;
         tick_q <= 1'b0;
         clk_q  <= '0;
      end else begin
         tick_q <= (pre_q == PRE_MAX);
         pre_q  <= (pre_q == PRE_MAX) ? '0 : pre_q + PW'(1);
         if (tick_o)
            clk_q <= clk_q + 32'd1;
      end
   end

   always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
      if (!sys_rst_n_i)
         shadow_q <= '0;
      else if (rd_lo)
         shadow_q <= clk_q[31:16];
   end

   always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
      if (!sys_rst_n_i) begin
         flag_q <= '0;
         for (int k = 0; k < N_CH; k++) begin
            count_q[k]  <= '0;
            reload_q[k] <= '0;
            ctrl_q[k]   <= '0;
         end
      end else begin
         flag_q <= (flag_q & ~w1c) | expire;
         for (int k = 0; k < N_CH; k++) begin
            if (wr_cnt[k]) begin
               count_q[k]  <= io.io_wdata[CNT_W-1:0];
               reload_q[k] <= io.io_wdata[CNT_W-1:0];
            end else if (tick_o && ctrl_q[k][0]) begin
               if (count_q[k] > CNT_W'(1))
                  count_q[k] <= count_q[k] - CNT_W'(1);
               else if (count_q[k] == CNT_W'(1))
                  count_q[k] <= ctrl_q[k][1] ? reload_q[k] : '0;
            end
            if (wr_ctl[k])
               ctrl_q[k] <= io.io_wdata[1:0];
            else if (expire[k] && !ctrl_q[k][1])
               ctrl_q[k][0] <= 1'b0;
         end
      end
   end

   always_comb begin
      io.io_rdata = '0;
      unique case (1'b1)
         sel_lo: io.io_rdata = clk_q[15:0];
         sel_hi: io.io_rdata = shadow_q;
         sel_fl: io.io_rdata = 16'(flag_q);
         ch_hit: begin
            for (int k = 0; k < N_CH; k++) begin
               if (ch_idx == 4'(k))
                  io.io_rdata = off[1] ? {14'b0, ctrl_q[k]}
                                       : 16'(count_q[k]);
            end
         end
         default: io.io_rdata = '0;
      endcase
   end
endmodule
